// File: rtl/io_sampler.sv
// io_sampler: synchronised sensor inputs with sticky rising-edge flags and a
// bit-serial transmitter on a dmem-mapped window. Define IO_SAMPLER_DEBOUNCE_EN for per-channel debounce.
module io_sampler #(
    parameter int NUM_IN     = 8,
    parameter int DATA_W     = 32,
    parameter int DIV_RST    = 9,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_IN-1:0] in,
    input  logic              io_sel,
    input  logic              wEn,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              outSignal,
    output logic              busy,
    output logic              irq
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [2:0] A_IN   = 3'd0;
    localparam logic [2:0] A_EDGE = 3'd1;
    localparam logic [2:0] A_TX   = 3'd2;
    localparam logic [2:0] A_STAT = 3'd3;
    localparam logic [2:0] A_DIV  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // DIV is 16 bits wide and mapped into the low half of the bus word.
    if (DEB_CYCLES < 2 || NUM_IN < 1 || NUM_IN > 32 || DATA_W < 16 || DATA_W < NUM_IN) begin : g_param_check
        $error("io_sampler: parameter out of range");
    end

    logic [NUM_IN-1:0] sync1_q;
    logic [NUM_IN-1:0] sync2_q;
    logic [NUM_IN-1:0] prev_q;
    logic [NUM_IN-1:0] level_s;
    logic [NUM_IN-1:0] rise_s;
    logic [NUM_IN-1:0] clr_s;
    logic [NUM_IN-1:0] edge_q;
    logic [NUM_IN-1:0] edge_d;
    logic              irq_q;
    logic              irq_d;
    logic              ovr_q;
    logic              ovr_d;
    logic [15:0]       div_q;
    logic [15:0]       div_d;
    logic [DATA_W-1:0] tx_word_q;
    logic [DATA_W-1:0] tx_word_d;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              wr_s;
    logic              tx_start_s;
    logic              tx_ovr_s;

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [15:0]       tick_q;
    logic [15:0]       tick_d;
    logic [BIT_W-1:0]  bit_q;
    logic [BIT_W-1:0]  bit_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              out_q;
    logic              out_d;
    logic              busy_q;
    logic              busy_d;

    // Two-flop synchroniser plus previous-level register for edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= {NUM_IN{1'b0}};
            sync2_q <= {NUM_IN{1'b0}};
            prev_q  <= {NUM_IN{1'b0}};
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            prev_q  <= level_s;
        end
    end

`ifdef IO_SAMPLER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  deb_cnt_q [NUM_IN];
    logic [CNT_W-1:0]  deb_cnt_d [NUM_IN];
    logic [NUM_IN-1:0] level_q;
    logic [NUM_IN-1:0] level_d;

    // Level follows the synchroniser only after a run of DEB_CYCLES mismatching edges
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_IN; i++) begin
            deb_cnt_d[i] = {CNT_W{1'b0}};
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = sync2_q[i];
                    deb_cnt_d[i] = {CNT_W{1'b0}};
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
            end else begin
                deb_cnt_d[i] = {CNT_W{1'b0}};
            end
        end
    end

    // Debounce counters and filtered level
    always_ff @(posedge clock) begin
        if (!reset) begin
            level_q <= {NUM_IN{1'b0}};
            for (int i = 0; i < NUM_IN; i++) begin
                deb_cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < NUM_IN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign level_s = level_q;
`else
    assign level_s = sync2_q;
`endif

    // Bus decode, sticky flags, control registers and read mux
    always_comb begin
        wr_s       = io_sel & wEn;
        tx_start_s = wr_s && (addr == A_TX) && (state_q == S_IDLE);
        tx_ovr_s   = wr_s && (addr == A_TX) && (state_q != S_IDLE);
        rise_s     = level_s & ~prev_q;

        if (wr_s && (addr == A_EDGE)) begin
            clr_s = dataIn[NUM_IN-1:0];
        end else begin
            clr_s = {NUM_IN{1'b0}};
        end
        // A rising edge in the same cycle as its clear keeps the flag set.
        edge_d = (edge_q & ~clr_s) | rise_s;
        irq_d  = |edge_d;

        if (tx_ovr_s) begin
            ovr_d = 1'b1;
        end else if (wr_s && (addr == A_STAT) && dataIn[1]) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        if (wr_s && (addr == A_DIV) && (state_q == S_IDLE)) begin
            div_d = dataIn[15:0];
        end else begin
            div_d = div_q;
        end

        if (tx_start_s) begin
            tx_word_d = dataIn;
        end else begin
            tx_word_d = tx_word_q;
        end

        rdata_s = {DATA_W{1'b0}};
        case (addr)
            A_IN:    rdata_s[NUM_IN-1:0] = level_s;
            A_EDGE:  rdata_s[NUM_IN-1:0] = edge_q;
            A_TX:    rdata_s             = tx_word_q;
            A_STAT:  rdata_s[1:0]        = {ovr_q, busy_q};
            A_DIV:   rdata_s[15:0]       = div_q;
            default: rdata_s             = {DATA_W{1'b0}};
        endcase

        if (io_sel) begin
            dout_d = rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Register file and read data port
    always_ff @(posedge clock) begin
        if (!reset) begin
            edge_q    <= {NUM_IN{1'b0}};
            irq_q     <= 1'b0;
            ovr_q     <= 1'b0;
            div_q     <= 16'(DIV_RST);
            tx_word_q <= {DATA_W{1'b0}};
            dout_q    <= {DATA_W{1'b0}};
        end else begin
            edge_q    <= edge_d;
            irq_q     <= irq_d;
            ovr_q     <= ovr_d;
            div_q     <= div_d;
            tx_word_q <= tx_word_d;
            dout_q    <= dout_d;
        end
    end

    // Serializer next state: each bit lasts DIV+1 clocks, data shifted out MSB first
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (tx_start_s) begin
                    state_d = S_START;
                    tick_d  = 16'd0;
                    shift_d = dataIn;
                    out_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    out_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_START: begin
                if (tick_q == div_q) begin
                    state_d = S_DATA;
                    tick_d  = 16'd0;
                    bit_d   = {BIT_W{1'b0}};
                    out_d   = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tick_q == div_q) begin
                    tick_d = 16'd0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        out_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        out_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tick_q == div_q) begin
                    state_d = S_IDLE;
                    tick_d  = 16'd0;
                    out_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = 16'd0;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Serializer state register; reset aborts any frame in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tick_q  <= 16'd0;
            bit_q   <= {BIT_W{1'b0}};
            shift_q <= {DATA_W{1'b0}};
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign dataOut   = dout_q;
    assign outSignal = out_q;
    assign busy      = busy_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_io_sampler.sv
// Self-checking bench for io_sampler: frame/busy behaviour is predicted from
// frame start time and bit period; edge flags from the sequence of applied input values.
module tb_io_sampler;

    localparam int NUM_IN  = 8;
    localparam int DATA_W  = 32;
    localparam int DIV_RST = 9;
    localparam int DEB     = 4;
`ifdef IO_SAMPLER_DEBOUNCE_EN
    localparam int IRQ_STEPS = 3 + DEB;
    localparam int HOLD      = DEB + 1;
`else
    localparam int IRQ_STEPS = 3;
    localparam int HOLD      = 1;
`endif

    localparam logic [2:0] A_IN   = 3'd0;
    localparam logic [2:0] A_EDGE = 3'd1;
    localparam logic [2:0] A_TX   = 3'd2;
    localparam logic [2:0] A_STAT = 3'd3;
    localparam logic [2:0] A_DIV  = 3'd4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_IN-1:0] sens = '0;
    logic              io_sel = 1'b0;
    logic              wEn = 1'b0;
    logic [2:0]        addr = 3'd0;
    logic [DATA_W-1:0] dataIn = '0;
    logic [DATA_W-1:0] dataOut;
    logic              outSignal;
    logic              busy;
    logic              irq;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model of the transmitter: one frame described by start edge, word and period
    int          m_start;
    int          m_fdiv;
    int          m_div;
    logic [31:0] m_word;
    logic        m_ovr;

    io_sampler #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .DIV_RST(DIV_RST), .DEB_CYCLES(DEB)) dut (
        .clock(clock), .reset(reset), .in(sens), .io_sel(io_sel), .wEn(wEn),
        .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .outSignal(outSignal),
        .busy(busy), .irq(irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    function automatic int flen(int div);
        return (DATA_W + 2) * (div + 1);
    endfunction

    function automatic logic exp_busy(int c);
        return (m_start >= 0) && (c >= m_start) && (c < m_start + flen(m_fdiv));
    endfunction

    function automatic logic exp_out(int c);
        int b;
        if (!exp_busy(c)) return 1'b1;
        b = (c - m_start) / (m_fdiv + 1);
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return m_word[DATA_W - b];
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_start = -1;
        m_fdiv  = 0;
        m_div   = DIV_RST;
        m_word  = '0;
        m_ovr   = 1'b0;
    endfunction

    task automatic step();
        @(negedge clock);
        io_sel = 1'b0;
        wEn    = 1'b0;
    endtask

    // Drive a write for the coming edge and apply its effect to the model
    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        io_sel = 1'b1; wEn = 1'b1; addr = a; dataIn = d;
        if (a == A_TX) begin
            if (exp_busy(cyc)) m_ovr = 1'b1;
            else begin m_start = cyc + 1; m_word = d; m_fdiv = m_div; end
        end else if (a == A_STAT) begin
            if (d[1]) m_ovr = 1'b0;
        end else if (a == A_DIV) begin
            if (!exp_busy(cyc)) m_div = int'(d[15:0]);
        end
    endtask

    task automatic drive_rd(input logic [2:0] a);
        io_sel = 1'b1; wEn = 1'b0; addr = a;
    endtask

    task automatic test_reset();
        reset = 1'b0; sens = '1; model_reset();
        repeat (3) step();
        n_total++; if (dataOut !== 32'd0) $display("FAIL reset_dataOut got %h want %h", dataOut, 32'd0); else n_pass++;
        n_total++; if (outSignal !== 1'b1) $display("FAIL reset_out got %b want 1", outSignal); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
        sens = '0; reset = 1'b1;
        repeat (4) step();
        drive_rd(A_DIV); step();
        n_total++; if (dataOut !== 32'd9) $display("FAIL div_reset got %0d want 9", dataOut); else n_pass++;
        drive_wr(A_DIV, 32'd5); step();
        n_total++; if (dataOut !== 32'd9) $display("FAIL read_during_write got %0d want 9", dataOut); else n_pass++;
        drive_rd(A_DIV); step();
        n_total++; if (dataOut !== 32'd5) $display("FAIL div_write got %0d want 5", dataOut); else n_pass++;
        drive_wr(3'd6, 32'hFFFF_FFFF); step();
        drive_rd(3'd6); step();
        n_total++; if (dataOut !== 32'd0) $display("FAIL unmapped_read got %h want 0", dataOut); else n_pass++;
        drive_rd(A_TX); step();
        n_total++; if (dataOut !== 32'd0) $display("FAIL tx_reset got %h want 0", dataOut); else n_pass++;
    endtask

    task automatic test_edge_capture();
        sens = '0; repeat (IRQ_STEPS) step();
        drive_wr(A_EDGE, 32'hFFFF_FFFF); step();
        sens[3] = 1'b1;
        for (int j = 1; j <= IRQ_STEPS; j++) begin
            step();
            n_total++;
            if (irq !== (j >= IRQ_STEPS)) $display("FAIL irq_latency step %0d got %b want %b", j, irq, (j >= IRQ_STEPS));
            else n_pass++;
        end
        drive_rd(A_EDGE); step();
        n_total++; if (dataOut !== 32'h8) $display("FAIL edge3 got %h want %h", dataOut, 32'h8); else n_pass++;
        sens[5] = 1'b1;
        repeat (IRQ_STEPS - 1) step();
        drive_wr(A_EDGE, 32'h8); step();
        drive_rd(A_EDGE); step();
        n_total++; if (dataOut !== 32'h20) $display("FAIL edge_clear3_set5 got %h want %h", dataOut, 32'h20); else n_pass++;
        sens[5] = 1'b0;
        repeat (IRQ_STEPS) step();
        drive_wr(A_EDGE, 32'h20); step();
        drive_rd(A_EDGE); step();
        n_total++; if (dataOut !== 32'h0) $display("FAIL edge_w1c got %h want 0", dataOut); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL irq_cleared got %b want 0", irq); else n_pass++;
        sens[5] = 1'b1;
        repeat (IRQ_STEPS - 1) step();
        drive_wr(A_EDGE, 32'h20); step();
        drive_rd(A_EDGE); step();
        n_total++; if (dataOut !== 32'h20) $display("FAIL edge_set_wins got %h want %h", dataOut, 32'h20); else n_pass++;
        n_total++; if (irq !== 1'b1) $display("FAIL irq_set_wins got %b want 1", irq); else n_pass++;
        drive_rd(A_IN); step();
        n_total++; if (dataOut !== 32'h28) $display("FAIL in_levels got %h want %h", dataOut, 32'h28); else n_pass++;
    endtask

    task automatic test_edge_random();
        logic [NUM_IN-1:0] prev;
        logic [NUM_IN-1:0] nv;
        logic [NUM_IN-1:0] mdl;
        logic [NUM_IN-1:0] mask;
        sens = '0; repeat (IRQ_STEPS + 1) step();
        drive_wr(A_EDGE, 32'hFFFF_FFFF); step();
        prev = '0; mdl = '0;
        for (int it = 0; it < 25; it++) begin
            nv = NUM_IN'($urandom);
            sens = nv;
            mdl = mdl | (nv & ~prev);
            prev = nv;
            repeat (HOLD) step();
            if (it % 5 == 4) begin
                repeat (IRQ_STEPS + 1) step();
                drive_rd(A_EDGE); step();
                n_total++; if (dataOut !== {24'd0, mdl}) $display("FAIL edge_rand it %0d got %h want %h", it, dataOut, {24'd0, mdl}); else n_pass++;
                n_total++; if (irq !== (|mdl)) $display("FAIL irq_rand it %0d got %b want %b", it, irq, |mdl); else n_pass++;
                drive_rd(A_IN); step();
                n_total++; if (dataOut !== {24'd0, prev}) $display("FAIL in_rand it %0d got %h want %h", it, dataOut, {24'd0, prev}); else n_pass++;
                mask = NUM_IN'($urandom);
                drive_wr(A_EDGE, {24'd0, mask}); step();
                mdl = mdl & ~mask;
            end
        end
        sens = '0; repeat (IRQ_STEPS + 1) step();
        drive_wr(A_EDGE, 32'hFFFF_FFFF); step();
    endtask

    task automatic test_frame();
        drive_wr(A_DIV, 32'd1); step();
        drive_wr(A_TX, 32'hA500_0001);
        for (int k = 0; k < 72; k++) begin
            step();
            n_total++; if (outSignal !== exp_out(cyc)) $display("FAIL frame_out k %0d got %b want %b", k, outSignal, exp_out(cyc)); else n_pass++;
            n_total++; if (busy !== exp_busy(cyc)) $display("FAIL frame_busy k %0d got %b want %b", k, busy, exp_busy(cyc)); else n_pass++;
            if (k == 13) begin
                n_total++; if (dataOut !== 32'h3) $display("FAIL stat_ovr got %h want 3", dataOut); else n_pass++;
            end
            if (k == 17) begin
                n_total++; if (dataOut !== 32'h1) $display("FAIL stat_clr got %h want 1", dataOut); else n_pass++;
            end
            if (k == 10) drive_wr(A_TX, 32'h1234);
            if (k == 12) drive_rd(A_STAT);
            if (k == 14) drive_wr(A_STAT, 32'h2);
            if (k == 16) drive_rd(A_STAT);
            if (k == 20) drive_wr(A_DIV, 32'd7);
        end
        drive_rd(A_DIV); step();
        n_total++; if (dataOut !== 32'd1) $display("FAIL div_busy_ignored got %0d want 1", dataOut); else n_pass++;
        drive_rd(A_TX); step();
        n_total++; if (dataOut !== 32'hA500_0001) $display("FAIL tx_readback got %h want %h", dataOut, 32'hA500_0001); else n_pass++;
    endtask

    task automatic test_abort();
        drive_wr(A_TX, $urandom);
        for (int k = 0; k < 23; k++) begin
            step();
            n_total++; if (outSignal !== exp_out(cyc)) $display("FAIL abort_pre_out k %0d got %b want %b", k, outSignal, exp_out(cyc)); else n_pass++;
        end
        reset = 1'b0; model_reset();
        step();
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        n_total++; if (outSignal !== 1'b1) $display("FAIL abort_out got %b want 1", outSignal); else n_pass++;
        reset = 1'b1;
        step();
        drive_wr(A_TX, $urandom);
        for (int k = 0; k < flen(DIV_RST) + 3; k++) begin
            step();
            n_total++; if (outSignal !== exp_out(cyc)) $display("FAIL post_abort_out k %0d got %b want %b", k, outSignal, exp_out(cyc)); else n_pass++;
            n_total++; if (busy !== exp_busy(cyc)) $display("FAIL post_abort_busy k %0d got %b want %b", k, busy, exp_busy(cyc)); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int          div;
        int          s0;
        int          fl;
        logic [31:0] w2;
        logic [31:0] stat;
        for (int f = 0; f < 4; f++) begin
            div = (f == 0) ? 0 : int'($urandom_range(1, 3));
            drive_wr(A_DIV, 32'(div)); step();
            drive_wr(A_TX, $urandom);
            s0 = cyc + 1; fl = flen(div); w2 = $urandom;
            for (int k = 0; k < 2 * fl + 4; k++) begin
                step();
                n_total++; if (outSignal !== exp_out(cyc)) $display("FAIL b2b_out f %0d k %0d got %b want %b", f, k, outSignal, exp_out(cyc)); else n_pass++;
                n_total++; if (busy !== exp_busy(cyc)) $display("FAIL b2b_busy f %0d k %0d got %b want %b", f, k, busy, exp_busy(cyc)); else n_pass++;
                if ((f % 2 == 1) && (cyc == s0 + fl - 1)) drive_wr(A_TX, $urandom);
                else if (cyc == s0 + fl) drive_wr(A_TX, w2);
            end
            stat = {30'd0, m_ovr, exp_busy(cyc)};
            drive_rd(A_STAT); step();
            n_total++; if (dataOut !== stat) $display("FAIL b2b_stat f %0d got %h want %h", f, dataOut, stat); else n_pass++;
            drive_wr(A_STAT, 32'h2); step();
            drive_rd(A_TX); step();
            n_total++; if (dataOut !== w2) $display("FAIL b2b_tx f %0d got %h want %h", f, dataOut, w2); else n_pass++;
        end
    endtask

`ifdef IO_SAMPLER_DEBOUNCE_EN
    task automatic test_debounce();
        sens = '0; repeat (IRQ_STEPS + 1) step();
        drive_wr(A_EDGE, 32'hFFFF_FFFF); step();
        sens[0] = 1'b1; repeat (3) step();
        sens[0] = 1'b0; repeat (10) step();
        drive_rd(A_EDGE); step();
        n_total++; if (dataOut !== 32'h0) $display("FAIL deb_short_edge got %h want 0", dataOut); else n_pass++;
        drive_rd(A_IN); step();
        n_total++; if (dataOut !== 32'h0) $display("FAIL deb_short_level got %h want 0", dataOut); else n_pass++;
        sens[0] = 1'b1; repeat (6) step();
        sens[0] = 1'b0; repeat (10) step();
        drive_rd(A_EDGE); step();
        n_total++; if (dataOut !== 32'h1) $display("FAIL deb_long_edge got %h want 1", dataOut); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_edge_capture();
        test_edge_random();
        test_frame();
        test_abort();
        test_back_to_back();
`ifdef IO_SAMPLER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_sampler.md
# io_sampler

Parametrised input-capture and serial-output peripheral on the processor's data-memory bus, the next-generation replacement for the fixed eight single-bit sensor inputs and single output line at the top level. It synchronises NUM_IN asynchronous inputs, optionally debounces them, latches sticky rising-edge flags, and serialises a processor-written word onto one output pin with a programmable bit period. The top level decodes a window of dmem addresses to `io_sel`; reads return through a registered data port, matching RAM read latency.

## Interface
- NUM_IN, 8: input channel count, 1..32
- DATA_W, 32: bus and transmit word width
- DIV_RST, 9: reset value of DIV (bit period = DIV+1 clocks)
- DEB_CYCLES, 4: debounce stability length in clocks, ≥2 (used only with macro)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; one clock, one reset, no other reset path
- in  in  NUM_IN  asynchronous sensor inputs
- io_sel  in  1  bus access targets this block
- wEn  in  1  write strobe, qualified by io_sel
- addr  in  3  register word index
- dataIn  in  DATA_W  write data
- dataOut  out  DATA_W  registered read data
- outSignal  out  1  serial output, idles high
- busy  out  1  frame in progress
- irq  out  1  OR of all EDGE bits

## Operation
- Register map (addr): 0 IN (RO, levels zero-extended); 1 EDGE (sticky rising flags, write-1-to-clear); 2 TX (W: start frame; R: last accepted word); 3 STAT (bit0 busy, bit1 OVR sticky, write-1 to bit1 clears); 4 DIV (RW, 16 bits, upper bits read 0); 5–7 read 0, writes ignored.
- Input path: 2-flop synchroniser per channel → level. EDGE[i] set when level[i] goes 0→1.
- EDGE set and write-1-clear of the same bit in one cycle: set wins.
- TX write while idle: load shift register, busy←1. While busy: data dropped, OVR←1, frame unaffected.
- DIV write while busy: ignored. DIV=0 is legal (1 clock/bit).
- Frame: start bit 0, DATA_W data bits MSB first, stop bit 1; each bit held DIV+1 clocks.
- Serializer FSM: IDLE → (TX write) START → DATA (count DATA_W bits) → STOP → IDLE.
- Reset values: dataOut 0, outSignal 1, busy 0, irq 0, levels 0, synchronisers 0, EDGE 0, OVR 0, TX 0, DIV DIV_RST, FSM IDLE.
- Reset mid-frame aborts the frame; outSignal returns to 1 on that edge.

## Timing
- Read: addr/io_sel sampled at edge k; dataOut valid after edge k; holds until the next sampled read. Read-during-write returns the pre-write value.
- Input (no debounce): in changes before edge k → level updates at edge k+1 → EDGE/irq at edge k+2.
- TX write accepted at edge t: outSignal=0 from edge t; data bit j (MSB=0) starts at edge t+(j+1)(DIV+1); stop bit starts at t+(DATA_W+1)(DIV+1).
- busy falls at edge t+(DATA_W+2)(DIV+1). A TX write sampled on that same edge still sees busy=1 and sets OVR.
- Earliest back-to-back frame: TX write one cycle after busy falls.

## Configuration
- IO_SAMPLER_DEBOUNCE_EN defined: each channel has a counter of ceil(log2(DEB_CYCLES)) bits. The counter increments while the synchroniser output differs from level, and clears when they are equal. When the counter reaches DEB_CYCLES−1 with a mismatch, level takes the new value and the counter clears. Level changes DEB_CYCLES edges after the synchroniser output changes, provided the input is stable. Glitches shorter than that are suppressed. Reset clears all counters.
- Not defined: level is the synchroniser output directly; no counters are instantiated.

## Test plan
- Reset: hold reset=0 for 3 clocks with in=8'hFF → dataOut=0, outSignal=1, busy=0, irq=0. After release, read DIV → 9.
- Edge capture: raise in[3] → irq high 3 edges later, EDGE reads 32'h8. Write EDGE=32'h8 in the same cycle in[5] rises → EDGE reads 32'h20.
- Frame: DIV=1, write TX=32'hA5000001 → start bit low for 2 clocks, then bits 1,0,1,0,… each 2 clocks. busy falls 68 clocks after the write, and outSignal stays 1.
- Overrun: during that frame write TX=32'h1234 → frame bits unchanged, STAT reads 32'h3. Write STAT=2 → STAT reads 32'h1.
- Abort: assert reset at bit 10 of a frame → next edge busy=0, outSignal=1. A new TX write afterwards transmits normally.
- Debounce (macro defined, DEB_CYCLES=4): 3-clock pulse on in[0] → level and EDGE stay 0. 6-clock pulse → EDGE[0]=1.
